// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched
//   Shares the register file's single write port between the in-order WB stage
//   and the multi-cycle mul/div unit. It keeps a scoreboard of registers whose
//   mul/div result is still outstanding, and it raises the ID-stage hazard stall.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   wb_we/wb_rd/wb_wd        pipeline writeback request
//   md_valid/md_rd/md_wd     mul/div result; accepted when md_valid && md_ready
//   md_ready                 the hold buffer is free
//   iss_valid/iss_rd         mul/div dispatch from ID; marks iss_rd busy
//   id_valid/id_rs1/rs2/rd   operands of the instruction in ID
//   id_stall                 stall IF/ID (hazard or forced starvation drain)
//   rf_we/rf_rd/rf_wd        register file write port
//   busy                     scoreboard; bit n is set while xn awaits mul/div
module regfile_wb_sched #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_wd,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_wd,
  output logic        md_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  output logic        id_stall,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wd,
  output logic [31:0] busy
);

  localparam int AW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW-1:0] LIM = AW'(STARVE_LIMIT);

  logic          hv;
  logic [4:0]    hrd;
  logic [31:0]   hwd;
  logic [AW-1:0] age;

  logic          wb_act, md_take;
  logic          hold_load, hold_drain;
  logic          clr_en;
  logic [4:0]    clr_rd;
  logic [31:0]   busy_nxt;
  logic          hazard, forced;

  // A write to x0 is dropped, so it never claims the port.
  assign wb_act   = wb_we && (wb_rd != 5'd0);
  assign md_ready = !hv && !rst;
  // A result for x0 is still handshaken, then discarded.
  assign md_take  = md_valid && md_ready && (md_rd != 5'd0);

  // Fixed priority: WB, then the held result, then a direct mul/div write.
  always_comb begin
    rf_we      = 1'b0;
    rf_rd      = 5'd0;
    rf_wd      = 32'd0;
    hold_load  = 1'b0;
    hold_drain = 1'b0;
    clr_en     = 1'b0;
    clr_rd     = 5'd0;
    if (!rst) begin
      if (wb_act) begin
        rf_we     = 1'b1;
        rf_rd     = wb_rd;
        rf_wd     = wb_wd;
        hold_load = md_take;
      end else if (hv) begin
        rf_we      = 1'b1;
        rf_rd      = hrd;
        rf_wd      = hwd;
        hold_drain = 1'b1;
        clr_en     = 1'b1;
        clr_rd     = hrd;
      end else if (md_take) begin
        rf_we  = 1'b1;
        rf_rd  = md_rd;
        rf_wd  = md_wd;
        clr_en = 1'b1;
        clr_rd = md_rd;
      end
    end
  end

  // The set is applied after the clear, so a same-register set/clear leaves it busy.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_rd] = 1'b0;
    if (iss_valid && (iss_rd != 5'd0)) busy_nxt[iss_rd] = 1'b1;
  end

  // busy[0] is never set, so x0 operands never stall.
  assign hazard   = id_valid && (busy[id_rs1] || busy[id_rs2] || busy[id_rd]);
  // A starved hold result drains the front end, so that a WB bubble reaches the port.
  assign forced   = hv && (age >= LIM);
  assign id_stall = !rst && (hazard || forced);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 32'd0;
      hv   <= 1'b0;
      hrd  <= 5'd0;
      hwd  <= 32'd0;
      age  <= '0;
    end else begin
      busy <= busy_nxt;
      if (hold_load) begin
        hv  <= 1'b1;
        hrd <= md_rd;
        hwd <= md_wd;
      end else if (hold_drain) begin
        hv  <= 1'b0;
      end
      if (hold_drain)
        age <= '0;
      else if (hv && wb_act && (age != LIM))
        age <= age + AW'(1);
    end
  end

endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-port scheduler and scoreboard for the 32x32 register file in the pipelined core. Arbitrates the file's single write port between the in-order pipeline writeback and the multi-cycle mul/div unit. Tracks registers whose long-latency results are outstanding, and generates the ID-stage hazard stall. Sits between the WB stage, the mul/div unit, and the register file's `reg_write`/`rd`/`wd` inputs.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: number of consecutive cycles a held mul/div result may lose arbitration before the front end is forced to stall.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wb_we` in 1: pipeline writeback request.
- `wb_rd` in 5: pipeline destination register.
- `wb_wd` in 32: pipeline write data.
- `md_valid` in 1: mul/div result valid.
- `md_rd` in 5: mul/div destination register.
- `md_wd` in 32: mul/div result data.
- `md_ready` out 1: scheduler can accept a mul/div result this cycle.
- `iss_valid` in 1: a mul/div op is dispatched from ID this cycle.
- `iss_rd` in 5: destination register of the dispatched op.
- `id_valid` in 1: ID holds a valid instruction.
- `id_rs1` in 5: ID source register 1.
- `id_rs2` in 5: ID source register 2.
- `id_rd` in 5: ID destination register.
- `id_stall` out 1: stall IF/ID this cycle.
- `rf_we` out 1: register file write enable.
- `rf_rd` out 5: register file write address.
- `rf_wd` out 32: register file write data.
- `busy` out 32: scoreboard bit vector; bit n set means xn has a pending mul/div write.

## Operation
- State:
  - `busy[31:0]`.
  - Hold buffer: `hv`, `hrd[4:0]`, `hwd[31:0]`.
  - Starvation counter `age`, wide enough for `STARVE_LIMIT`.
- Effective pipeline request: `A = wb_we && wb_rd != 0`. A request with `wb_rd == 0` is dropped and does not occupy the port.
- Handshake: `md_ready = !hv`. A mul/div result is accepted when `md_valid && md_ready`. A result with `md_rd == 0` is accepted and discarded; no write, no hold.
- Write-port priority, fixed per cycle:
  1. `A`: write `wb_rd`/`wb_wd`. A held entry stays held. An accepted mul/div result (`md_rd != 0`) is captured into the hold buffer (`hv <= 1`).
  2. Otherwise, if `hv`: write `hrd`/`hwd` and clear `hv`. `md_ready` is 0, so nothing new is accepted.
  3. Otherwise, if a mul/div result is accepted with `md_rd != 0`: write it directly. There is no hold and no added latency.
  4. Otherwise: `rf_we = 0`.
- Scoreboard:
  - `iss_valid && iss_rd != 0` sets `busy[iss_rd]`.
  - A mul/div write committing to the register file (case 2 or 3) clears `busy[rd]`.
  - If set and clear target the same register in the same cycle, set wins.
- Hazard: `id_stall = id_valid && (busy[id_rs1] || busy[id_rs2] || busy[id_rd])`, with x0 never busy. This covers RAW on both sources and WAW on the destination. `id_stall` is also forced to 1 whenever `hv && age >= STARVE_LIMIT`.
- Starvation counter:
  - `age` increments each cycle that `hv` is set and case 1 occurs, saturating at `STARVE_LIMIT`.
  - It clears when `hv` clears.
  - The forced stall drains the front end so a WB bubble reaches the port.
- Dispatch is the ID stage's responsibility: it does not assert `iss_valid` while `id_stall` is 1.

## Timing
- `rf_we`/`rf_rd`/`rf_wd`, `md_ready` and `id_stall` are combinational from inputs and current state. The register file commits on the same rising edge.
- Mul/div result latency to the register file:
  - 0 cycles when the port is free.
  - Otherwise 1 to N cycles, leaving the hold buffer the first cycle `A` is low.
- `busy` set/clear is visible on the cycle after the edge. An instruction in ID that reads a register cleared this cycle therefore stalls one extra cycle. This is accepted, and the regfile's write-then-read ordering is not relied on.
- Reset, including mid-operation:
  - `busy = 0`, `hv = 0`, `age = 0`.
  - The held result is discarded.
  - `rf_we = 0` and `id_stall = 0` in the reset cycle; `md_ready = 1` from the first cycle after reset.
  - Inputs are ignored while `rst` is high.

## Test plan
- Free-port direct write: `iss_valid`, `iss_rd=5` → `busy[5]=1` next cycle. Then `md_valid`, `md_rd=5`, `md_wd=32'hDEAD_BEEF` with `wb_we=0` → same cycle `rf_we=1`, `rf_rd=5`, `rf_wd=DEADBEEF`; `busy[5]=0` next cycle.
- Collision: `wb_we=1`/`wb_rd=3`/`wb_wd=7` and `md_valid`/`md_rd=4`/`md_wd=9` in the same cycle → `rf_rd=3`, `rf_wd=7`, `hv=1`, `md_ready=0`. Next cycle with `wb_we=0` → `rf_rd=4`, `rf_wd=9`, `md_ready=1` again.
- Hazard: `busy[8]=1`, `id_valid=1`, `id_rs2=8` → `id_stall=1`; same for `id_rd=8`. With `id_rs1=0` and all other registers idle → `id_stall=0`. `iss_rd=0` never sets `busy[0]`.
- Starvation: `hv=1` with `wb_we=1` (nonzero rd) for 4 cycles at `STARVE_LIMIT=4` → `id_stall` forced high on the 5th cycle. First cycle `wb_we=0` → held write commits, `age=0`, forced stall drops.
- Zero destinations: `wb_we=1`/`wb_rd=0` with `md_valid`/`md_rd=6` → `rf_we=1` with `rf_rd=6` (direct path). `md_rd=0` → accepted, `rf_we=0`, no hold.
- Reset mid-hold: `hv=1`, `busy=32'h0000_0100`, then `rst=1` for one cycle → `hv=0`, `busy=0`, `md_ready=1`, `rf_we=0`; the held data is never written.
